// File: rtl/mmu_walker_if.sv
// Page-table memory read port used by mmu_walker (master drives the request side).
interface mmu_walker_if #(
  parameter int RV = 16,
  parameter int PA = RV
);
  logic          mem_req;
  logic [PA-1:0] mem_addr;
  logic          mem_ack;
  logic [RV-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mmu_walker.sv
// Hardware TLB refill walker: fetches one PTE on an MMU miss and writes it back.
// Optional FETCH timeout is enabled by defining MMU_WALK_TIMEOUT_EN.
module mmu_walker #(
  parameter int RV        = 16,
  parameter int PA        = RV,
  parameter int VA        = RV,
  parameter int NMMU      = 8,
  parameter int UNTOUCHED = VA - $clog2(NMMU)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          miss_req,
  input  logic [RV-1:0] fault_reg,
  input  logic [PA-1:0] ptbr_u,
  input  logic [PA-1:0] ptbr_s,
  mmu_walker_if.master  mem,
  output logic          reg_write,
  output logic [RV-1:0] reg_data,
  output logic          busy,
  output logic          done,
  output logic          walk_fault
);

  localparam int PGW = VA - UNTOUCHED;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE,
    FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [PA-1:0] addr_q, addr_d;
  logic [RV-1:0] pte_q, pte_d;
  logic          walk_fault_q, walk_fault_d;
  logic [PA-1:0] pte_base;
  logic [PA-1:0] pte_off;
  logic          unused_bits;

`ifdef MMU_WALK_TIMEOUT_EN
  logic [3:0]    cnt_q, cnt_d;
`endif

  // PTE address is computed once at capture so mem_addr stays stable even if ptbr_* moves.
  always_comb begin
    pte_off            = '0;
    pte_off[PGW+1:0]   = {fault_reg[3], fault_reg[VA-1:UNTOUCHED], 1'b0};
    pte_base           = fault_reg[2] ? ptbr_s : ptbr_u;
  end

  always_comb begin
    unused_bits = ^{fault_reg[0], fault_reg[UNTOUCHED-1:4], pte_q[0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pte_q        <= '0;
      walk_fault_q <= 1'b0;
`ifdef MMU_WALK_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pte_q        <= pte_d;
      walk_fault_q <= walk_fault_d;
`ifdef MMU_WALK_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pte_d   = pte_q;
`ifdef MMU_WALK_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          addr_d  = pte_base + pte_off;
          state_d = fault_reg[1] ? FETCH : FAULT;
`ifdef MMU_WALK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      FETCH: begin
        if (mem.mem_ack) begin
          pte_d   = mem.mem_rdata;
          state_d = mem.mem_rdata[1] ? WRITE : FAULT;
        end
`ifdef MMU_WALK_TIMEOUT_EN
        else if (cnt_q == 4'hF) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // walk_fault is registered off FAULT, so it fires two cycles after the triggering event.
  always_comb begin
    walk_fault_d = (state_q == FAULT);
  end

  always_comb begin
    mem.mem_req  = (state_q == FETCH);
    mem.mem_addr = mem.mem_req ? addr_q : '0;
    reg_write    = (state_q == WRITE);
    reg_data     = reg_write ? {pte_q[RV-1:3], pte_q[2], 2'b11} : '0;
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    walk_fault   = walk_fault_q;
  end

endmodule
